// File: rtl/alu_seq_pkg.sv
// Shared types for the multi-nibble ALU sequencer: opcodes, ALU select codes,
// FSM states and the opcode decoder.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADC  = 3'd1,
        OP_SUB  = 3'd2,
        OP_INC  = 3'd3,
        OP_NOR  = 3'd4,
        OP_MOVB = 3'd5
    } op_e;

    localparam logic [3:0] S_INC   = 4'h0;
    localparam logic [3:0] S_NOR   = 4'h1;
    localparam logic [3:0] S_SUB   = 4'h6;
    localparam logic [3:0] S_ADD   = 4'h9;
    localparam logic [3:0] S_PASSB = 4'ha;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        CIN_ZERO,
        CIN_ONE,
        CIN_FLAG
    } cin_src_e;

    typedef struct packed {
        logic       legal;
        logic       m;
        logic [3:0] s;
        cin_src_e   cin_src;
        logic       is_arith;
    } dec_t;

    // Opcodes 6 and 7 fall through to the all-zero, illegal decode.
    function automatic dec_t decode_op(input logic [2:0] op);
        dec_t d;
        d = '{legal: 1'b0, m: 1'b0, s: 4'h0, cin_src: CIN_ZERO, is_arith: 1'b0};
        case (op)
            OP_ADD:  d = '{1'b1, 1'b0, S_ADD,   CIN_ZERO, 1'b1};
            OP_ADC:  d = '{1'b1, 1'b0, S_ADD,   CIN_FLAG, 1'b1};
            OP_SUB:  d = '{1'b1, 1'b0, S_SUB,   CIN_ONE,  1'b1};
            OP_INC:  d = '{1'b1, 1'b0, S_INC,   CIN_ONE,  1'b1};
            OP_NOR:  d = '{1'b1, 1'b1, S_NOR,   CIN_ZERO, 1'b0};
            OP_MOVB: d = '{1'b1, 1'b1, S_PASSB, CIN_ZERO, 1'b0};
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command, response and ALU-side signals of the sequencer. The slave modport is
// the sequencer; the master modport is the decoder/ALU environment around it.
interface alu_seq_if #(parameter int NIB = 4);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [1:0]         cmd_len;
    logic [4*NIB-1:0]   cmd_a;
    logic [4*NIB-1:0]   cmd_b;

    logic [3:0]         alu_a;
    logic [3:0]         alu_b;
    logic [3:0]         alu_s;
    logic               alu_m;
    logic               alu_crin;
    logic [3:0]         alu_f;
    logic               alu_crout;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [4*NIB-1:0]   rsp_f;
    logic               rsp_carry;
    logic               rsp_zero;
    logic               rsp_err;
    logic               carry_flag;

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_a, cmd_b,
        input  alu_f, alu_crout,
        input  rsp_ready,
        output cmd_ready,
        output alu_a, alu_b, alu_s, alu_m, alu_crin,
        output rsp_valid, rsp_f, rsp_carry, rsp_zero, rsp_err, carry_flag
    );

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_a, cmd_b,
        output alu_f, alu_crout,
        output rsp_ready,
        input  cmd_ready,
        input  alu_a, alu_b, alu_s, alu_m, alu_crin,
        input  rsp_valid, rsp_f, rsp_carry, rsp_zero, rsp_err, carry_flag
    );

endinterface

// File: rtl/alu_seq.sv
// Drives a 4-bit combinational ALU one nibble per cycle, LSB first, chaining
// carry between nibbles, and returns the assembled result on a handshake.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int NIB = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);

    state_e               r_state;
    state_e               w_next;
    logic [2:0]           r_op;
    logic [1:0]           r_len;
    logic [1:0]           r_idx;
    logic [NIB-1:0][3:0]  r_a;
    logic [NIB-1:0][3:0]  r_b;
    logic [NIB-1:0][3:0]  r_res;
    logic [NIB-1:0][3:0]  w_res;
    logic                 r_chain;
    logic                 r_rsp_carry;
    logic                 r_zero;
    logic                 r_err;
    logic                 r_carry_flag;
    dec_t                 w_dec_cmd;
    dec_t                 w_dec_run;
    logic                 w_init_carry;
    logic                 w_carry_next;
    logic                 w_last;

    assign w_dec_cmd    = decode_op(bus.cmd_op);
    assign w_dec_run    = decode_op(r_op);
    assign w_last       = (r_idx == r_len);
    assign w_carry_next = w_dec_run.is_arith & bus.alu_crout;

    always_comb begin
        w_init_carry = 1'b0;
        case (w_dec_cmd.cin_src)
            CIN_ONE:  w_init_carry = 1'b1;
            CIN_FLAG: w_init_carry = r_carry_flag;
            default:  w_init_carry = 1'b0;
        endcase
    end

    // Result as it will look after this cycle's nibble lands; feeds the zero flag.
    always_comb begin
        w_res        = r_res;
        w_res[r_idx] = bus.alu_f;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        bus.alu_a    = 4'h0;
        bus.alu_b    = 4'h0;
        bus.alu_s    = 4'h0;
        bus.alu_m    = 1'b0;
        bus.alu_crin = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_next = w_dec_cmd.legal ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                bus.alu_a    = r_a[r_idx];
                bus.alu_b    = r_b[r_idx];
                bus.alu_s    = w_dec_run.s;
                bus.alu_m    = w_dec_run.m;
                bus.alu_crin = r_chain;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= 3'd0;
            r_len        <= 2'd0;
            r_idx        <= 2'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_chain      <= 1'b0;
            r_rsp_carry  <= 1'b0;
            r_zero       <= 1'b0;
            r_err        <= 1'b0;
            r_carry_flag <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_op    <= bus.cmd_op;
                        r_len   <= bus.cmd_len;
                        r_a     <= bus.cmd_a;
                        r_b     <= bus.cmd_b;
                        r_idx   <= 2'd0;
                        r_res   <= '0;
                        r_err   <= ~w_dec_cmd.legal;
                        r_chain <= w_init_carry;
                        if (!w_dec_cmd.legal) begin
                            r_rsp_carry <= r_carry_flag;
                            r_zero      <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_res   <= w_res;
                    r_chain <= w_carry_next;
                    if (w_last) begin
                        r_rsp_carry <= w_carry_next;
                        r_zero      <= ~|w_res;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready && !r_err) begin
                        r_carry_flag <= r_rsp_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.rsp_valid  = (r_state == ST_DONE);
    assign bus.rsp_f      = r_res;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_zero   = r_zero;
    assign bus.rsp_err    = r_err;
    assign bus.carry_flag = r_carry_flag;

endmodule
